// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, pin decode
// and default timing for a 20 MHz reference clock.
package pll_seq_pkg;

  localparam logic [2:0] ST_HOLD      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;
  localparam logic [2:0] ST_BYPASS    = 3'd5;

  typedef enum logic [2:0] {
    S_HOLD      = ST_HOLD,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_STABLE    = ST_STABLE,
    S_RUN       = ST_RUN,
    S_FAULT     = ST_FAULT,
    S_BYPASS    = ST_BYPASS
  } state_t;

  // 20 MHz reference: 1 us hold, 100 us lock budget, 3.2 us stable window.
  localparam int unsigned DEF_RESET_HOLD_CYCLES   = 20;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 2000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 64;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_CNT_W               = 16;

  typedef struct packed {
    logic resetb;
    logic bypass;
    logic sys_reset;
    logic locked;
    logic fault;
  } pins_t;

  function automatic pins_t state_pins(input state_t s);
    pins_t p;
    p = pins_t'(5'b00100);
    case (s)
      S_HOLD:      p = pins_t'(5'b00100);
      S_WAIT_LOCK: p = pins_t'(5'b10100);
      S_STABLE:    p = pins_t'(5'b10100);
      S_RUN:       p = pins_t'(5'b10010);
      S_FAULT:     p = pins_t'(5'b11001);
      S_BYPASS:    p = pins_t'(5'b11100);
      default:     p = pins_t'(5'b00100);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by a
// synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the reference clock domain: holds the PLL in
// reset, qualifies lock, retries on timeout and falls back to bypass.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       RESTART,
  input  logic       FORCE_BYPASS,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       SYS_RESET,
  output logic       LOCKED,
  output logic       FAULT,
  output logic [1:0] RETRY_COUNT,
  output logic [2:0] seq_state
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             lock_s;
  logic             hold_done, stable_done, timeout_hit;
  pins_t            pins_d;

  sync_2ff u_lock_sync (
    .clk (REFERENCECLK),
    .rst (RESET),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

  assign hold_done   = (cnt_q >= HOLD_LAST);
  assign stable_done = (cnt_q == STABLE_LAST);
  assign timeout_hit = (tcnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;

    if (FORCE_BYPASS) begin
      state_d = S_BYPASS;
    end else if (RESTART) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_done) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            tcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        S_WAIT_LOCK, S_STABLE: begin
          if (!timeout_hit) tcnt_d = tcnt_q + ONE;
          // Stable completion is checked before the timeout so that a lock
          // qualifying on the last allowed cycle still reaches RUN.
          if (state_q == S_WAIT_LOCK && lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (state_q == S_STABLE && !lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (state_q == S_STABLE && stable_done) begin
            state_d = S_RUN;
          end else if (timeout_hit) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              state_d = S_HOLD;
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = S_FAULT;
            end
          end else if (state_q == S_STABLE) begin
            cnt_d = cnt_q + ONE;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            retry_d = '0;
          end
        end

        S_FAULT: state_d = S_FAULT;

        S_BYPASS: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end

        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end

    pins_d = state_pins(state_d);
  end

  // Pins are decoded from the next state so every output is a flop.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      retry_q    <= '0;
      PLL_RESETB <= 1'b0;
      PLL_BYPASS <= 1'b0;
      SYS_RESET  <= 1'b1;
      LOCKED     <= 1'b0;
      FAULT      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      retry_q    <= retry_d;
      PLL_RESETB <= pins_d.resetb;
      PLL_BYPASS <= pins_d.bypass;
      SYS_RESET  <= pins_d.sys_reset;
      LOCKED     <= pins_d.locked;
      FAULT      <= pins_d.fault;
    end
  end

  assign RETRY_COUNT = retry_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with HOLD=4, TIMEOUT=50, STABLE=8,
// MAX_RETRIES=2; outs packs {PLL_RESETB,PLL_BYPASS,SYS_RESET,LOCKED,FAULT}.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       restart;
  logic       force_bypass;
  logic       pll_resetb, pll_bypass, sys_reset, locked, fault;
  logic [1:0] retry_count;
  logic [2:0] seq_state;
  logic [4:0] outs;

  int tests_run;
  int tests_failed;

  assign outs = {pll_resetb, pll_bypass, sys_reset, locked, fault};

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES (50),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (16)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .PLL_LOCK     (pll_lock),
    .RESTART      (restart),
    .FORCE_BYPASS (force_bypass),
    .PLL_RESETB   (pll_resetb),
    .PLL_BYPASS   (pll_bypass),
    .SYS_RESET    (sys_reset),
    .LOCKED       (locked),
    .FAULT        (fault),
    .RETRY_COUNT  (retry_count),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b0; restart = 1'b0; force_bypass = 1'b0;
    step(2);
    tests_run++; if (outs !== 5'b00100) begin tests_failed++; $display("FAIL reset_outs got=%b exp=%b", outs, 5'b00100); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
    tests_run++; if (seq_state !== ST_HOLD) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", seq_state, ST_HOLD); end
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    step(3);
    tests_run++; if (outs !== 5'b00100) begin tests_failed++; $display("FAIL pu_hold_low got=%b exp=%b", outs, 5'b00100); end
    step(1);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL pu_hold_release got=%b exp=%b", outs, 5'b10100); end
    tests_run++; if (seq_state !== ST_WAIT_LOCK) begin tests_failed++; $display("FAIL pu_wait_state got=%0d exp=%0d", seq_state, ST_WAIT_LOCK); end
    step(6);
    pll_lock = 1'b1;
    step(10);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL pu_lock_early got=%b exp=%b", outs, 5'b10100); end
    step(1);
    tests_run++; if (outs !== 5'b10010) begin tests_failed++; $display("FAIL pu_lock_11 got=%b exp=%b", outs, 5'b10010); end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    step(2);
    tests_run++; if (outs !== 5'b10010) begin tests_failed++; $display("FAIL loss_early got=%b exp=%b", outs, 5'b10010); end
    step(1);
    tests_run++; if (outs !== 5'b00100) begin tests_failed++; $display("FAIL loss_3 got=%b exp=%b", outs, 5'b00100); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL loss_retry got=%0d exp=0", retry_count); end
    pll_lock = 1'b1;
    step(3);
    tests_run++; if (outs !== 5'b00100) begin tests_failed++; $display("FAIL loss_hold got=%b exp=%b", outs, 5'b00100); end
    step(1);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL loss_wait got=%b exp=%b", outs, 5'b10100); end
    step(8);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL relock_early got=%b exp=%b", outs, 5'b10100); end
    step(1);
    tests_run++; if (outs !== 5'b10010) begin tests_failed++; $display("FAIL relock got=%b exp=%b", outs, 5'b10010); end
  endtask

  task automatic test_glitch();
    pll_lock = 1'b0; restart = 1'b1;
    step(1);
    restart = 1'b0;
    tests_run++; if (seq_state !== ST_HOLD) begin tests_failed++; $display("FAIL gl_restart_state got=%0d exp=%0d", seq_state, ST_HOLD); end
    step(4);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL gl_wait got=%b exp=%b", outs, 5'b10100); end
    pll_lock = 1'b1;
    step(8);
    tests_run++; if (seq_state !== ST_STABLE) begin tests_failed++; $display("FAIL gl_stable got=%0d exp=%0d", seq_state, ST_STABLE); end
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(2);
    tests_run++; if (seq_state !== ST_WAIT_LOCK) begin tests_failed++; $display("FAIL gl_back_wait got=%0d exp=%0d", seq_state, ST_WAIT_LOCK); end
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL gl_not_locked got=%b exp=%b", outs, 5'b10100); end
    step(8);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL gl_lock_early got=%b exp=%b", outs, 5'b10100); end
    step(1);
    tests_run++; if (outs !== 5'b10010) begin tests_failed++; $display("FAIL gl_lock_11 got=%b exp=%b", outs, 5'b10010); end
  endtask

  task automatic test_timeout();
    pll_lock = 1'b0;
    step(3);
    tests_run++; if (seq_state !== ST_HOLD) begin tests_failed++; $display("FAIL to_hold got=%0d exp=%0d", seq_state, ST_HOLD); end
    step(4);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL to_wait0 got=%b exp=%b", outs, 5'b10100); end
    step(49);
    tests_run++; if ({outs, retry_count} !== {5'b10100, 2'd0}) begin tests_failed++; $display("FAIL to_pre1 got=%b/%0d exp=10100/0", outs, retry_count); end
    step(1);
    tests_run++; if ({outs, retry_count} !== {5'b00100, 2'd1}) begin tests_failed++; $display("FAIL to_retry1 got=%b/%0d exp=00100/1", outs, retry_count); end
    step(3);
    tests_run++; if (pll_resetb !== 1'b0) begin tests_failed++; $display("FAIL to_pulse1_low got=%b exp=0", pll_resetb); end
    step(1);
    tests_run++; if (pll_resetb !== 1'b1) begin tests_failed++; $display("FAIL to_pulse1_end got=%b exp=1", pll_resetb); end
    step(49);
    tests_run++; if (retry_count !== 2'd1) begin tests_failed++; $display("FAIL to_pre2 got=%0d exp=1", retry_count); end
    step(1);
    tests_run++; if ({outs, retry_count} !== {5'b00100, 2'd2}) begin tests_failed++; $display("FAIL to_retry2 got=%b/%0d exp=00100/2", outs, retry_count); end
    step(4);
    tests_run++; if (pll_resetb !== 1'b1) begin tests_failed++; $display("FAIL to_pulse2_end got=%b exp=1", pll_resetb); end
    step(49);
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL to_pre_fault got=%b exp=0", fault); end
    step(1);
    tests_run++; if ({outs, retry_count} !== {5'b11001, 2'd2}) begin tests_failed++; $display("FAIL to_fault got=%b/%0d exp=11001/2", outs, retry_count); end
    step(5);
    tests_run++; if (seq_state !== ST_FAULT) begin tests_failed++; $display("FAIL to_fault_sticky got=%0d exp=%0d", seq_state, ST_FAULT); end
  endtask

  task automatic test_restart_reset();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    tests_run++; if ({outs, retry_count} !== {5'b00100, 2'd0}) begin tests_failed++; $display("FAIL rs_restart got=%b/%0d exp=00100/0", outs, retry_count); end
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(3);
    tests_run++; if (outs !== 5'b00100) begin tests_failed++; $display("FAIL rs_hold_restarted got=%b exp=%b", outs, 5'b00100); end
    step(1);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL rs_hold_done got=%b exp=%b", outs, 5'b10100); end
    step(5);
    rst = 1'b1;
    step(1);
    tests_run++; if ({outs, retry_count} !== {5'b00100, 2'd0}) begin tests_failed++; $display("FAIL rs_reset got=%b/%0d exp=00100/0", outs, retry_count); end
    tests_run++; if (seq_state !== ST_HOLD) begin tests_failed++; $display("FAIL rs_reset_state got=%0d exp=%0d", seq_state, ST_HOLD); end
    rst = 1'b0;
    pll_lock = 1'b1;
  endtask

  task automatic test_bypass();
    step(4);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL by_wait got=%b exp=%b", outs, 5'b10100); end
    step(2);
    tests_run++; if (seq_state !== ST_STABLE) begin tests_failed++; $display("FAIL by_stable got=%0d exp=%0d", seq_state, ST_STABLE); end
    force_bypass = 1'b1;
    step(1);
    tests_run++; if (outs !== 5'b11100) begin tests_failed++; $display("FAIL by_enter got=%b exp=%b", outs, 5'b11100); end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    tests_run++; if (seq_state !== ST_BYPASS) begin tests_failed++; $display("FAIL by_restart_ignored got=%0d exp=%0d", seq_state, ST_BYPASS); end
    step(8);
    tests_run++; if (outs !== 5'b11100) begin tests_failed++; $display("FAIL by_held got=%b exp=%b", outs, 5'b11100); end
    force_bypass = 1'b0;
    step(1);
    tests_run++; if ({outs, retry_count} !== {5'b00100, 2'd0}) begin tests_failed++; $display("FAIL by_release got=%b/%0d exp=00100/0", outs, retry_count); end
    step(4);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL by_rehold got=%b exp=%b", outs, 5'b10100); end
    step(8);
    tests_run++; if (outs !== 5'b10100) begin tests_failed++; $display("FAIL by_relock_early got=%b exp=%b", outs, 5'b10100); end
    step(1);
    tests_run++; if (outs !== 5'b10010) begin tests_failed++; $display("FAIL by_relock got=%b exp=%b", outs, 5'b10010); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_glitch();
    test_timeout();
    test_restart_reset();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
